seq_pattern_gen: RTL and testbench

//   Serial pattern transmitter that drives the stimulus side of the serial sequence detectors.
//   - Shifts a PAT_W-bit pattern out MSB-first, one bit per clk.
//   - Repeats the pattern a programmable number of frames, with a programmable idle gap between frames.
//   - Drives data_out straight into a detector's Data_in, in sim benches and on-chip self-test.

---
 rtl/seq_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first in bursts of frames with
// a programmable idle gap. Optional LSB error injection is enabled by SEQ_GEN_ERR_INJECT_EN.
module seq_pattern_gen #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int unsigned      CNT_W   = 8,
    parameter int unsigned      GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             stop,
`ifdef SEQ_GEN_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    output logic             data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] fsent_q, fsent_d;
    logic             stop_q, stop_d;
    logic             data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             stop_any;
    logic             send_next;
    logic [IDX_W-1:0] bit_sel;
    logic             flip;
`ifdef SEQ_GEN_ERR_INJECT_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        gap_len_d = gap_len_q;
        rep_d     = rep_q;
        fsent_d   = fsent_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        stop_any  = stop_q | stop;

        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (load) pat_d = pattern_in;
                if (start) begin
                    fsent_d = '0;
                    if (repeat_cnt != '0) begin
                        rep_d     = repeat_cnt;
                        gap_len_d = gap_len;
                        bit_idx_d = '0;
                        state_d   = StSend;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSend: begin
                stop_d = stop_any;
                if (bit_idx_q == LastIdx) begin
                    fsent_d   = fsent_q + CNT_W'(1);
                    bit_idx_d = '0;
                    if (fsent_d == rep_q || stop_any) begin
                        state_d = StIdle;
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (gap_len_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                    end
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            StGap: begin
                // A stop seen in the gap ends the burst without sending another frame.
                if (stop_any) begin
                    state_d = StIdle;
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    state_d   = StSend;
                    bit_idx_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        send_next = (state_d == StSend);
        bit_sel   = LastIdx - bit_idx_d;
        flip      = 1'b0;
`ifdef SEQ_GEN_ERR_INJECT_EN
        err_d = err_q | err_inject;
        if (send_next && bit_idx_d == LastIdx && err_d) begin
            flip  = 1'b1;
            err_d = 1'b0;
        end
`endif
        data_out_d = send_next & (pat_d[bit_sel] ^ flip);
        valid_d    = send_next;
        fs_d       = send_next && (bit_idx_d == '0);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pat_q      <= PATTERN;
            bit_idx_q  <= '0;
            gap_cnt_q  <= '0;
            gap_len_q  <= '0;
            rep_q      <= '0;
            fsent_q    <= '0;
            stop_q     <= 1'b0;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            bit_idx_q  <= bit_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_len_q  <= gap_len_d;
            rep_q      <= rep_d;
            fsent_q    <= fsent_d;
            stop_q     <= stop_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef SEQ_GEN_ERR_INJECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`endif

    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = fsent_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: a burst-level trace model checked every cycle, plus
// literal checks on serial streams, pulse counts and done timing.
module tb_seq_pattern_gen;

    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] pattern_in = '0;
    logic       start = 1'b0;
    logic [7:0] repeat_cnt = '0;
    logic [3:0] gap_len = '0;
    logic       stop = 1'b0;
`ifdef SEQ_GEN_ERR_INJECT_EN
    logic       err_inject = 1'b0;
`endif
    logic       data_out, data_valid, frame_start, busy, done;
    logic [7:0] frames_sent;

    seq_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .pattern_in (pattern_in),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .stop       (stop),
`ifdef SEQ_GEN_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       d;
        logic       fs;
        logic       b;
        logic       dn;
        logic [7:0] fc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_fsent = '0;
    logic [3:0] model_pat = 4'b1011;
    logic       chk_en = 1'b0;
    int         n_checks = 0;
    int         n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected per-cycle trace of a burst, from its frame/gap structure. Cycle 1 is the cycle after
    // start is sampled; stop_k is the cycle at whose end stop is sampled (-1: none).
    task automatic build_burst(input logic [3:0] pat, input int n, input int gap,
                               input int stop_k, input int err_f);
        exp_t e;
        int   t;
        bit   stop_here;
        t = 1;
        e = '0;
        if (n == 0) begin
            e.dn = 1'b1;
            exp_q.push_back(e);
            return;
        end
        for (int f = 0; f < n; f++) begin
            stop_here = 1'b0;
            for (int b = 0; b < PW; b++) begin
                e = '0;
                e.v = 1'b1;
                e.d = pat[PW-1-b];
                if (b == PW - 1 && f == err_f) e.d = ~e.d;
                e.fs = (b == 0);
                e.b = 1'b1;
                e.fc = 8'(f);
                exp_q.push_back(e);
                if (t == stop_k) stop_here = 1'b1;
                t++;
            end
            if (stop_here || f == n - 1) begin
                e = '0;
                e.dn = 1'b1;
                e.fc = 8'(f + 1);
                exp_q.push_back(e);
                return;
            end
            for (int g = 0; g < gap; g++) begin
                e = '0;
                e.b = 1'b1;
                e.fc = 8'(f + 1);
                exp_q.push_back(e);
                if (t == stop_k) begin
                    e = '0;
                    e.dn = 1'b1;
                    e.fc = 8'(f + 1);
                    exp_q.push_back(e);
                    return;
                end
                t++;
            end
        end
    endtask

    // Every-cycle comparison against the model; an empty queue means idle with frames_sent held.
    initial begin
        exp_t       e;
        logic [12:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                e = '0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    model_fsent = e.fc;
                end else begin
                    e.fc = model_fsent;
                end
                act = {data_valid, data_out, frame_start, busy, done, frames_sent};
                n_checks++;
                if (act !== 13'(e)) begin
                    n_err++;
                    $display("FAIL cycle_cmp t=%0t v/d/fs/busy/done/frames actual=%b required=%b",
                             $time, act, 13'(e));
                end
            end
        end
    end

    // Starts a burst from a negedge, then watches it until done, optionally poking stop, a
    // busy-time start and load, and err_inject at given cycles.
    task automatic burst(input logic ld, input logic [3:0] pin, input logic [7:0] rc,
                         input logic [3:0] gl, input int stop_k, input int err_f,
                         input int bstart_k, input int bload_k, input int err_k,
                         output logic [31:0] ser, output int fsc, output int vc, output int bc,
                         output int dc, output int fsent_at_done);
        ser = '0; fsc = 0; vc = 0; bc = 0; dc = 0; fsent_at_done = -1;
        @(negedge clk);
        if (ld) model_pat = pin;
        build_burst(model_pat, int'(rc), int'(gl), stop_k, err_f);
        load = ld; pattern_in = pin; start = 1'b1; repeat_cnt = rc; gap_len = gl;
        @(negedge clk);
        start = 1'b0; load = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (busy) bc++;
            if (frame_start) fsc++;
            if (data_valid) begin
                vc++;
                ser = {ser[30:0], data_out};
            end
            if (done) begin
                dc = c;
                fsent_at_done = int'(frames_sent);
                break;
            end
            stop = (c == stop_k);
            start = (c == bstart_k);
            if (c == bstart_k) repeat_cnt = 8'd1;
            load = (c == bload_k);
            pattern_in = (c == bload_k) ? 4'b0000 : pin;
`ifdef SEQ_GEN_ERR_INJECT_EN
            err_inject = (c == err_k);
`endif
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0; load = 1'b0;
`ifdef SEQ_GEN_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_err++;
            $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] ser;
        int          fsc, vc, bc, dc, fd;

        #12;
        chk("reset_outputs", int'({data_valid, data_out, frame_start, busy, done}), 0);
        chk("reset_frames_sent", int'(frames_sent), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame, no gap.
        burst(1'b0, 4'b0000, 8'd1, 4'd0, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t1_serial", int'(ser[3:0]), 4'b1011);
        chk("t1_valid_cnt", vc, 4);
        chk("t1_frame_start_cnt", fsc, 1);
        chk("t1_done_cycle", dc, 5);
        chk("t1_frames_sent", fd, 1);

        // 2: three frames with a two-cycle gap.
        burst(1'b0, 4'b0000, 8'd3, 4'd2, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t2_serial", int'(ser[11:0]), 12'b1011_1011_1011);
        chk("t2_frame_start_cnt", fsc, 3);
        chk("t2_busy_cycles", bc, 16);
        chk("t2_done_cycle", dc, 17);
        chk("t2_frames_sent", fd, 3);

        // 3: load alone, then a zero-length burst, then the loaded pattern goes out.
        @(negedge clk);
        load = 1'b1; pattern_in = 4'b1100; model_pat = 4'b1100;
        @(negedge clk);
        load = 1'b0;
        burst(1'b0, 4'b1100, 8'd0, 4'd3, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t3_zero_done_cycle", dc, 1);
        chk("t3_zero_valid_cnt", vc, 0);
        chk("t3_zero_busy_cycles", bc, 0);
        chk("t3_zero_frames_sent", fd, 0);
        burst(1'b0, 4'b1100, 8'd1, 4'd0, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t3_loaded_serial", int'(ser[3:0]), 4'b1100);
        burst(1'b1, 4'b0110, 8'd2, 4'd0, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t3_load_with_start_serial", int'(ser[7:0]), 8'b0110_0110);
        chk("t3_back_to_back_fs_cnt", fsc, 2);
        chk("t3_back_to_back_done", dc, 9);

        // 4: stop in frame 2 of 5; start and load while busy are ignored.
        burst(1'b0, 4'b0110, 8'd5, 4'd1, 7, -1, 3, 6, -1, ser, fsc, vc, bc, dc, fd);
        chk("t4_serial", int'(ser[7:0]), 8'b0110_0110);
        chk("t4_done_cycle", dc, 10);
        chk("t4_frames_sent", fd, 2);

        // Stop during a gap ends the burst at once.
        burst(1'b0, 4'b0110, 8'd4, 4'd3, 5, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t4_gap_stop_done", dc, 6);
        chk("t4_gap_stop_frames", fd, 1);

        // 5: reset mid-frame.
        @(negedge clk);
        build_burst(model_pat, 3, 0, -1, -1);
        start = 1'b1; repeat_cnt = 8'd3; gap_len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_reset_outputs", int'({data_valid, data_out, frame_start, busy, done}), 0);
        chk("t5_reset_frames_sent", int'(frames_sent), 0);
        exp_q.delete();
        model_fsent = '0;
        model_pat = 4'b1011;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        burst(1'b0, 4'b0000, 8'd1, 4'd0, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t5_pattern_restored", int'(ser[3:0]), 4'b1011);

`ifdef SEQ_GEN_ERR_INJECT_EN
        // 6: error injected in the gap corrupts the LSB of the second frame only.
        burst(1'b0, 4'b0000, 8'd2, 4'd2, -1, 1, -1, -1, 5, ser, fsc, vc, bc, dc, fd);
        chk("t6_serial", int'(ser[7:0]), 8'b1011_1010);
        burst(1'b0, 4'b0000, 8'd1, 4'd0, -1, -1, -1, -1, -1, ser, fsc, vc, bc, dc, fd);
        chk("t6_flag_cleared", int'(ser[3:0]), 4'b1011);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
